// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl : fetch sequencer for the IF pipeline stage.
//
// Owns the fetch PC and drives an sram-like instruction-memory request
// handshake with at most one request outstanding. After a redirect it
// absorbs the stale response, and it holds one fetched instruction until
// ID accepts it. It also generates the write and flush strobes for the IF
// pipeline register.
//
// Optional feature: define IF_FETCH_PERF_EN to add two free-running 32-bit
// performance counters (fetches delivered, responses dropped).
//
// Ports:
//   clk              clock
//   rst              asynchronous active-low reset
//   exc_redirect     exception/eret redirect request (wins over branch)
//   exc_pc[31:0]     exception redirect target
//   br_redirect      branch/jump redirect request
//   br_pc[31:0]      branch redirect target
//   id_allow_in      ID can accept an instruction this cycle
//   inst_req         memory request valid
//   inst_addr[31:0]  memory request address (always the fetch PC)
//   inst_addr_ok     request accepted (only meaningful while inst_req=1)
//   inst_data_ok     read data returned
//   inst_rdata[31:0] read data
//   if_wr            IF register write enable
//   if_flush         IF register flush, one-cycle pulse after a redirect
//   if_pc[31:0]      PC of the held instruction
//   if_inst[31:0]    held instruction word
//   if_adel          held entry carries a fetch address-error exception
//   perf_fetch_cnt   (IF_FETCH_PERF_EN only) count of if_wr pulses
//   perf_discard_cnt (IF_FETCH_PERF_EN only) count of dropped responses
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_redirect,
  input  logic [31:0] exc_pc,
  input  logic        br_redirect,
  input  logic [31:0] br_pc,
  input  logic        id_allow_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_wr,
  output logic        if_flush,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DISCARD = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_flush;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_adel;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_inst_req;
  logic        w_addr_acc;
  logic        w_if_wr;
  logic        w_cap_data;
  logic        w_cap_adel;

  // Redirect resolution: exception target has priority over branch target.
  always_comb begin
    w_redirect = exc_redirect | br_redirect;
    if (exc_redirect) begin
      w_target = exc_pc;
    end else begin
      w_target = br_pc;
    end
  end

  // Request handshake and IF write strobe, decoded from the current state.
  always_comb begin
    w_misalign = (r_pc[1:0] != 2'b00);
    // A misaligned PC never reaches memory; it becomes an address-error entry.
    w_inst_req = (r_state == S_REQ) & ~w_misalign;
    w_addr_acc = w_inst_req & inst_addr_ok;
    w_if_wr    = (r_state == S_HOLD) & id_allow_in & ~w_redirect;
  end

  // Next-state, next-PC and capture decisions for the fetch sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cap_data  = 1'b0;
    w_cap_adel  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_redirect) begin
          // If the old address was already accepted its response is stale.
          w_pc_nxt = w_target;
          if (w_addr_acc) begin
            w_state_nxt = S_DISCARD;
          end else begin
            w_state_nxt = S_REQ;
          end
        end else if (w_misalign) begin
          w_cap_adel  = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_addr_acc) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
          // A coincident response retires the stale request right away.
          if (inst_data_ok) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DISCARD;
          end
        end else if (inst_data_ok) begin
          w_cap_data  = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (inst_data_ok) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (id_allow_in) begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // State, PC and flush-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_redirect & (r_state != S_IDLE);
    end
  end

  // Held instruction entry: loaded from memory data or as an address error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_pc   <= 32'h0000_0000;
      r_if_inst <= 32'h0000_0000;
      r_if_adel <= 1'b0;
    end else if (w_cap_data) begin
      r_if_pc   <= r_pc;
      r_if_inst <= inst_rdata;
      r_if_adel <= 1'b0;
    end else if (w_cap_adel) begin
      r_if_pc   <= r_pc;
      r_if_inst <= 32'h0000_0000;
      r_if_adel <= 1'b1;
    end else begin
      r_if_pc   <= r_if_pc;
      r_if_inst <= r_if_inst;
      r_if_adel <= r_if_adel;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_discard;
  logic        w_drop;

  // A response is dropped in DISCARD, or in WAIT when it meets a redirect.
  always_comb begin
    w_drop = inst_data_ok &
             ((r_state == S_DISCARD) | ((r_state == S_WAIT) & w_redirect));
  end

  // Wrapping performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch   <= 32'd0;
      r_perf_discard <= 32'd0;
    end else begin
      if (w_if_wr) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end else begin
        r_perf_fetch <= r_perf_fetch;
      end
      if (w_drop) begin
        r_perf_discard <= r_perf_discard + 32'd1;
      end else begin
        r_perf_discard <= r_perf_discard;
      end
    end
  end

  assign perf_fetch_cnt   = r_perf_fetch;
  assign perf_discard_cnt = r_perf_discard;
`endif

  assign inst_req  = w_inst_req;
  assign inst_addr = r_pc;
  assign if_wr     = w_if_wr;
  assign if_flush  = r_flush;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign if_adel   = r_if_adel;

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch sequencer for the IF stage.
- Owns the fetch PC and drives the sram-like instruction-memory request handshake.
- Absorbs stale responses after a redirect, holds one fetched instruction until ID accepts it.
- Generates the write and flush strobes for the IF pipeline register.

Parameters:
- RESET_PC, 32'hBFC0_0000: first fetch address after reset.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- exc_redirect  in  1  exception/eret redirect request
- exc_pc  in  32  exception redirect target
- br_redirect  in  1  branch/jump redirect request
- br_pc  in  32  branch redirect target
- id_allow_in  in  1  ID can accept an instruction this cycle
- inst_req  out  1  memory request valid
- inst_addr  out  32  memory request address
- inst_addr_ok  in  1  request accepted (sampled only while inst_req=1)
- inst_data_ok  in  1  read data returned (at most one outstanding)
- inst_rdata  in  32  read data
- if_wr  out  1  IF register write enable
- if_flush  out  1  IF register flush, one-cycle pulse
- if_pc  out  32  PC of the held instruction
- if_inst  out  32  held instruction word
- if_adel  out  1  held entry carries an address-error (fetch) exception

Behaviour:
- Redirect resolution: redirect = exc_redirect | br_redirect; target = exc_pc when exc_redirect, else br_pc (exception wins when both assert).
- States: IDLE, REQ, WAIT, DISCARD, HOLD. Only one request is ever outstanding.
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, inst_req=0, if_wr=0, if_flush=0, if_pc=0, if_inst=0, if_adel=0.
- IDLE: moves to REQ on the first clock after reset release; no request issued in IDLE.
- inst_addr = pc at all times; inst_req=1 only in REQ.
- REQ, pc[1:0]!=0:
  - inst_req forced 0.
  - Next state HOLD with if_adel=1, if_inst=0, if_pc=pc.
- REQ, redirect with inst_addr_ok=0: pc<=target, stay REQ. The address may change because the request was not accepted.
- REQ, redirect with inst_addr_ok=1: the old address was accepted; pc<=target, go to DISCARD.
- REQ, inst_addr_ok=1 and no redirect: go to WAIT.
- WAIT, redirect: pc<=target, go to DISCARD. A coincident inst_data_ok also completes the stale request, so go to REQ directly instead.
- WAIT, inst_data_ok and no redirect: capture if_inst=inst_rdata, if_pc=pc, if_adel=0, go to HOLD.
- DISCARD:
  - Redirect updates pc<=target (latest target wins).
  - On inst_data_ok, the data is dropped and the state goes to REQ.
- HOLD:
  - if_wr = id_allow_in & ~redirect.
  - On if_wr: pc<=pc+PC_STEP (wraps mod 2^32), go to REQ.
  - Redirect in HOLD: held entry dropped, if_wr=0, pc<=target, go to REQ.
- if_flush = registered pulse, high for exactly the cycle after any cycle in which redirect=1 (in every state except IDLE).
- if_wr is combinational from state/id_allow_in/redirect; it is never asserted outside HOLD.
- Best-case latency: REQ with addr_ok → WAIT → data_ok → HOLD. With zero-wait memory, if_wr asserts 2 cycles after the request is accepted.
- Reset mid-operation: all state is cleared immediately. A response for a request issued before reset is not protected; the memory side is reset by the same rst.
- Spurious inst_data_ok in IDLE/REQ/HOLD is ignored.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - perf_fetch_cnt[31:0]: increments on each if_wr.
  - perf_discard_cnt[31:0]: increments on each dropped response (DISCARD data_ok, or WAIT redirect with coincident data_ok).
  - Both counters wrap and reset to 0.
- When undefined, the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory, id_allow_in=1:
  - Addresses BFC00000, BFC00004 and BFC00008 are requested in order.
  - if_wr pulses with if_pc matching each address and if_inst=rdata.
- Redirect in WAIT (br_pc=80001000), data_ok 2 cycles later carrying 0xDEADBEEF:
  - Data dropped, no if_wr.
  - Next inst_addr=80001000; if_flush high for 1 cycle.
- exc_redirect (exc_pc=BFC00380) and br_redirect (br_pc=80002000) in the same cycle in HOLD:
  - Next fetch address is BFC00380.
  - Held entry discarded; if_wr=0 that cycle.
- Redirect to 80000002: no inst_req issued; HOLD with if_adel=1, if_pc=80000002, if_inst=0.
- id_allow_in=0 for 5 cycles in HOLD:
  - if_wr=0 and if_pc/if_inst stable; no new request.
  - On id_allow_in=1, a single if_wr occurs and pc advances by 4.
- Reset asserted in WAIT: outputs immediately return to reset values; after release, fetch restarts at RESET_PC.
